// File: rtl/ddr2_controller_dmaster_skid_timing_adt.sv
// Avalon-ST ready-latency adapter (IN_READY_LATENCY -> 0) built on a small fall-through FIFO.
// Optional sticky overflow detection is enabled with `define DDR2_TA_OVERFLOW_DETECT_EN.
module ddr2_controller_dmaster_skid_timing_adt #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 4,
    parameter int IN_READY_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     fill_level,
    output logic                           overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAT  = CW'(IN_READY_LATENCY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  in_ready_q;
    logic                  wr;
    logic                  rd;

    // Outputs read as idle during the reset cycle itself, before the registers clear.
    assign out_valid  = (count != '0) && !reset;
    assign fill_level = reset ? '0 : count;
    assign in_ready   = in_ready_q && !reset;
    assign out_data   = mem[rd_ptr];

    always_comb begin
        wr = in_valid && (count != FULL);
        rd = out_valid && out_ready;
        count_next = count;
        case ({wr, rd})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            // Headroom must cover every beat already committed by the upstream latency.
            in_ready_q <= (FULL - count_next) > LAT;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= in_data;
    end

`ifdef DDR2_TA_OVERFLOW_DETECT_EN
    logic overflow_q;
    logic drop;

    assign drop     = in_valid && (count == FULL);
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset)     overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && drop) $display("%m: beat dropped while FIFO full");
    end
`endif
`else
    assign overflow = 1'b0;
`endif

endmodule
